// File: rtl/sfir_coef_ctrl.sv
// rtl/sfir_coef_ctrl.sv - coefficient bank and sample-feed controller for a symmetric systolic FIR chain
// Shadow/active banks, valid tracking and drain-before-commit bank swaps.
module sfir_coef_ctrl #(
   parameter int TAPS       = 8,
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int ACC_WIDTH  = 40,
   parameter int LATENCY    = 20
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [DATA_WIDTH-1:0]        s_data_i,
   input  logic                         s_valid_i,
   output logic                         s_ready_o,
   input  logic                         coef_wr_i,
   input  logic [$clog2(TAPS)-1:0]      coef_addr_i,
   input  logic [COEF_WIDTH-1:0]        coef_data_i,
   input  logic                         swap_req_i,
   output logic                         swap_done_o,
   output logic                         busy_o,
   output logic [DATA_WIDTH-1:0]        chain_data_o,
   output logic [TAPS*COEF_WIDTH-1:0]   chain_coef_o,
   input  logic [ACC_WIDTH-1:0]         chain_acc_i,
   output logic [ACC_WIDTH-1:0]         m_data_o,
   output logic                         m_valid_o
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_COMMIT} state_t;

   state_t                       r_state;
   logic [COEF_WIDTH-1:0]        r_shadow [TAPS];
   logic [TAPS*COEF_WIDTH-1:0]   r_active;
   logic [LATENCY-1:0]           r_vsr;
   logic [DATA_WIDTH-1:0]        r_chain_data;
   logic [ACC_WIDTH-1:0]         r_m_data;
   logic                         r_m_valid;
   logic                         r_swap_done;
   logic                         r_busy;

   logic w_ready;
   logic w_hs;
   logic w_addr_ok;
   logic w_vsr_empty;

   // Ready is forced low while reset is held, independent of the state register.
   assign w_ready     = rstn_i && (r_state == ST_RUN);
   assign w_hs        = s_valid_i && w_ready;
   assign w_addr_ok   = (32'(coef_addr_i) < TAPS);
   assign w_vsr_empty = (r_vsr == '0);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= ST_RUN;
         r_active     <= '0;
         r_vsr        <= '0;
         r_chain_data <= '0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
         r_swap_done  <= 1'b0;
         r_busy       <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            r_shadow[k] <= '0;
         end
      end else begin
         r_chain_data <= w_hs ? s_data_i : '0;
         r_vsr        <= (r_vsr << 1) | LATENCY'(w_hs);
         r_m_data     <= chain_acc_i;
         r_m_valid    <= r_vsr[LATENCY-1];

         if (coef_wr_i && w_addr_ok) begin
            r_shadow[coef_addr_i] <= coef_data_i;
         end

         case (r_state)
            ST_RUN: begin
               // A sample taken in the request cycle is still in flight, so it forces a drain.
               if (swap_req_i) begin
                  r_busy <= 1'b1;
                  if (w_vsr_empty && !w_hs) begin
                     r_state     <= ST_COMMIT;
                     r_swap_done <= 1'b1;
                  end else begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_vsr_empty) begin
                  r_state     <= ST_COMMIT;
                  r_swap_done <= 1'b1;
               end
            end
            ST_COMMIT: begin
               for (int k = 0; k < TAPS; k++) begin
                  r_active[k*COEF_WIDTH +: COEF_WIDTH] <= r_shadow[k];
               end
               r_state     <= ST_RUN;
               r_swap_done <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= ST_RUN;
               r_swap_done <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o    = w_ready;
   assign swap_done_o  = r_swap_done;
   assign busy_o       = r_busy;
   assign chain_data_o = r_chain_data;
   assign chain_coef_o = r_active;
   assign m_data_o     = r_m_data;
   assign m_valid_o    = r_m_valid;

endmodule

// File: tb/tb_sfir_coef_ctrl.sv
// tb/tb_sfir_coef_ctrl.sv - self-checking bench for sfir_coef_ctrl
// Chain stub plus a delay-queue model of valid/data, with directed swap and reset scenarios.
module tb_sfir_coef_ctrl;
   localparam int T  = 8;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int AW = 40;
   localparam int L  = 20;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0]   s_data = '0;
   logic            s_valid = 1'b0;
   wire             s_ready;
   logic            coef_wr = 1'b0;
   logic [2:0]      coef_addr = '0;
   logic [CW-1:0]   coef_data = '0;
   logic            swap_req = 1'b0;
   wire             swap_done;
   wire             busy;
   wire  [DW-1:0]   chain_data;
   wire  [T*CW-1:0] chain_coef;
   logic [AW-1:0]   chain_acc = '0;
   wire  [AW-1:0]   m_data;
   wire             m_valid;

   logic            b_wr = 1'b0;
   logic [2:0]      b_addr = '0;
   logic [CW-1:0]   b_cdata = '0;
   logic            b_swap = 1'b0;
   wire             b_ready, b_done, b_busy, b_mvalid;
   wire  [DW-1:0]   b_cd;
   wire  [5*CW-1:0] b_coef;
   wire  [AW-1:0]   b_mdata;

   sfir_coef_ctrl #(.TAPS(T), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW), .LATENCY(L)) dut (
      .clk_i(clk), .rstn_i(rstn), .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
      .coef_wr_i(coef_wr), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
      .swap_req_i(swap_req), .swap_done_o(swap_done), .busy_o(busy),
      .chain_data_o(chain_data), .chain_coef_o(chain_coef), .chain_acc_i(chain_acc),
      .m_data_o(m_data), .m_valid_o(m_valid));

   // Five taps leave room in the 3-bit address for out-of-range indices.
   sfir_coef_ctrl #(.TAPS(5), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .ACC_WIDTH(AW), .LATENCY(3)) dut_b (
      .clk_i(clk), .rstn_i(rstn), .s_data_i('0), .s_valid_i(1'b0), .s_ready_o(b_ready),
      .coef_wr_i(b_wr), .coef_addr_i(b_addr), .coef_data_i(b_cdata),
      .swap_req_i(b_swap), .swap_done_o(b_done), .busy_o(b_busy),
      .chain_data_o(b_cd), .chain_coef_o(b_coef), .chain_acc_i('0),
      .m_data_o(b_mdata), .m_valid_o(b_mvalid));

   int checks = 0;
   int errors = 0;
   int exp_active [T];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Chain stub: acc = sample * sum(active taps) + 7, appearing L-1 cycles after chain_data.
   logic [AW-1:0] aq [$];
   logic          vq [$];
   logic [AW-1:0] dq [$];
   logic          prev_hs = 1'b0;
   logic [DW-1:0] prev_data = '0;

   initial begin
      repeat (L-1) aq.push_back('0);
      foreach (exp_active[k]) exp_active[k] = 0;
   end

   always @(negedge clk) begin
      longint        s;
      logic          hs;
      logic          ev;
      logic [AW-1:0] ed;
      s = 0;
      for (int k = 0; k < T; k++) s += longint'($signed(chain_coef[k*CW +: CW]));
      aq.push_back(AW'(longint'($signed(chain_data)) * s + 7));
      chain_acc = aq.pop_front();
      if (!rstn) begin
         vq = {};
         dq = {};
         repeat (L+1) begin
            vq.push_back(1'b0);
            dq.push_back('0);
         end
         prev_hs = 1'b0;
         prev_data = '0;
      end else begin
         hs = s_valid && s_ready;
         chk("chain_data", chain_data, prev_hs ? prev_data : '0);
         s = 0;
         for (int k = 0; k < T; k++) s += longint'(exp_active[k]);
         vq.push_back(hs);
         dq.push_back(AW'(longint'($signed(s_data)) * s + 7));
         ev = vq.pop_front();
         ed = dq.pop_front();
         chk("m_valid", m_valid, ev);
         if (ev) chk("m_data", m_data, ed);
         prev_hs = hs;
         prev_data = s_data;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n;
      int  idx;
      int  guard;
      int  pulses;
      int  pulses_at_done;
      int  low;
      logic sent;
      logic hs;
      logic seen;

      tick(3);
      chk("rst_ready", s_ready, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_coef", chain_coef, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", swap_done, 0);
      rstn = 1'b1;
      #1;
      chk("ready_after_rst", s_ready, 1);

      // Idle swap with taps 1..8
      for (int k = 0; k < T; k++) begin
         coef_wr = 1'b1; coef_addr = 3'(k); coef_data = CW'(k+1);
         tick(1);
      end
      coef_wr = 1'b0;
      chk("shadow_only", chain_coef, 0);
      swap_req = 1'b1;
      tick(1);
      swap_req = 1'b0;
      chk("idle_done", swap_done, 1);
      chk("idle_busy", busy, 1);
      tick(1);
      chk("idle_done_off", swap_done, 0);
      chk("idle_busy_off", busy, 0);
      chk("idle_coef", chain_coef, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      for (int k = 0; k < T; k++) exp_active[k] = k + 1;

      // Impulse: 1 * 36 + 7
      s_valid = 1'b1; s_data = 16'd1;
      tick(1);
      s_valid = 1'b0; s_data = '0;
      n = 0;
      while (m_valid !== 1'b1 && n < 100) begin
         tick(1);
         n++;
      end
      chk("impulse_latency", n, L);
      chk("impulse_data", m_data, 43);
      tick(1);
      chk("impulse_single", m_valid, 0);

      // Swap under streaming with taps 2,4,..16 pending
      for (int k = 0; k < T; k++) begin
         coef_wr = 1'b1; coef_addr = 3'(k); coef_data = CW'(2*(k+1));
         tick(1);
      end
      coef_wr = 1'b0;
      idx = 0; guard = 0; pulses = 0; pulses_at_done = -1; low = 0; sent = 1'b0;
      while (idx < 10 && guard < 200) begin
         s_valid = 1'b1;
         s_data = DW'(idx*37 - 100);
         swap_req = (idx == 5) && !sent;
         hs = s_ready;
         tick(1);
         guard++;
         if (hs) begin
            if (swap_req) sent = 1'b1;
            idx++;
         end
         swap_req = 1'b0;
         if (m_valid) pulses++;
         if (swap_done) begin
            pulses_at_done = pulses;
            for (int k = 0; k < T; k++) exp_active[k] = 2*(k+1);
         end
         if (sent && !s_ready) low++;
      end
      s_valid = 1'b0;
      chk("stream_bound", guard < 200, 1);
      repeat (L+5) begin
         tick(1);
         if (m_valid) pulses++;
      end
      chk("stream_pulses_before_done", pulses_at_done, 6);
      chk("stream_pulses_total", pulses, 10);
      chk("stream_ready_low", low, L+2);
      chk("stream_coef", chain_coef, 128'h0010_000e_000c_000a_0008_0006_0004_0002);

      // Bubbles
      for (int i = 0; i < 8; i++) begin
         s_valid = (i % 2 == 0);
         s_data = DW'(16'h100 + i);
         tick(1);
         chk("bubble_chain", chain_data, (i % 2 == 0) ? DW'(16'h100 + i) : DW'(0));
      end
      s_valid = 1'b0;
      tick(L+3);

      // Write coincident with COMMIT lands only in shadow
      swap_req = 1'b1;
      tick(1);
      swap_req = 1'b0;
      chk("commit_done", swap_done, 1);
      coef_wr = 1'b1; coef_addr = 3'd3; coef_data = 16'd99;
      tick(1);
      coef_wr = 1'b0;
      chk("commit_wr_old", chain_coef[3*CW +: CW], 8);
      swap_req = 1'b1;
      tick(1);
      swap_req = 1'b0;
      tick(1);
      chk("commit_wr_new", chain_coef[3*CW +: CW], 99);
      exp_active[3] = 99;

      // Reset during DRAIN
      s_valid = 1'b1; s_data = 16'd5; swap_req = 1'b1;
      tick(1);
      s_valid = 1'b0; swap_req = 1'b0;
      chk("drain_busy", busy, 1);
      tick(3);
      rstn = 1'b0;
      #1;
      chk("arst_ready", s_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_coef", chain_coef, 0);
      chk("arst_chain", chain_data, 0);
      chk("arst_mdata", m_data, 0);
      chk("arst_mvalid", m_valid, 0);
      foreach (exp_active[k]) exp_active[k] = 0;
      tick(2);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (L+10) begin
         tick(1);
         if (swap_done) seen = 1'b1;
      end
      chk("arst_no_done", seen, 0);
      chk("arst_coef_after", chain_coef, 0);

      // Out-of-range addresses on the 5-tap instance
      b_wr = 1'b1; b_addr = 3'd5; b_cdata = 16'h55;
      tick(1);
      b_addr = 3'd7;
      tick(1);
      b_addr = 3'd4; b_cdata = 16'd9;
      tick(1);
      b_wr = 1'b0;
      b_swap = 1'b1;
      tick(1);
      b_swap = 1'b0;
      chk("b_done", b_done, 1);
      tick(1);
      chk("b_coef", b_coef, 80'h0009_0000_0000_0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
